// File: rtl/bin_window_gen.sv
// KxK stride-1 binary window generator over a raster CH-bit pixel stream. Window appears one
// cycle after its bottom-right pixel is accepted; a stalled output holds window and drops in_ready.
module bin_window_gen #(
    parameter int CH = 1,
    parameter int K  = 3,
    parameter int W0 = 28,
    parameter int H0 = 28,
    parameter int W1 = 12,
    parameter int H1 = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH-1:0]     din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH*K*K-1:0] win,
    output logic              out_last
);
    localparam int WMAX  = (W0 > W1) ? W0 : W1;
    localparam int HMAX  = (H0 > H1) ? H0 : H1;
    localparam int DEPTH = (K - 1) * WMAX + K;
    localparam int CW    = $clog2(WMAX);
    localparam int RW    = $clog2(HMAX);

    logic [DEPTH-1:0] sr_q [CH];
    logic [DEPTH-1:0] sr_d [CH];
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             accept;
    logic             frame_start;
    logic             cur_mode;
    logic             hit;
    logic             row_end;
    logic             frame_end;
    logic [CW-1:0]    w_last;
    logic [RW-1:0]    h_last;

    assign in_ready    = !(out_valid_q && !out_ready);
    assign accept      = in_valid && in_ready;
    assign frame_start = (col_q == '0) && (row_q == '0);
    // The first pixel of a frame already runs under the newly requested mode.
    assign cur_mode    = frame_start ? mode : mode_q;
    assign w_last      = cur_mode ? CW'(W1 - 1) : CW'(W0 - 1);
    assign h_last      = cur_mode ? RW'(H1 - 1) : RW'(H0 - 1);
    assign hit         = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
    assign row_end     = (col_q == w_last);
    assign frame_end   = row_end && (row_q == h_last);

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    always_comb begin
        win = '0;
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < K; r++) begin
                for (int x = 0; x < K; x++) begin
                    win[c*K*K + r*K + x] = mode_q ? sr_q[c][(K-1-r)*W1 + (K-1-x)]
                                                  : sr_q[c][(K-1-r)*W0 + (K-1-x)];
                end
            end
        end
    end

    always_comb begin
        sr_d        = sr_q;
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (clear) begin
            // Shift data is left in place: it is overwritten before any window can reach it.
            col_d       = '0;
            row_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (accept) begin
            for (int c = 0; c < CH; c++) begin
                sr_d[c] = {sr_q[c][DEPTH-2:0], din[c]};
            end
            if (frame_start) begin
                mode_d = mode;
            end
            out_valid_d = hit;
            out_last_d  = hit && frame_end;
            if (row_end) begin
                col_d = '0;
                row_d = (row_q == h_last) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                sr_q[c] <= '0;
            end
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule

// File: tb/tb_bin_window_gen.sv
// Bench for bin_window_gen: reference image model feeds an expected-window queue.
module tb_bin_window_gen;
    localparam int CH = 1;
    localparam int K  = 3;
    localparam int KK = K * K;
    localparam int W0 = 28;
    localparam int H0 = 28;
    localparam int W1 = 12;
    localparam int H1 = 12;
    localparam int WMAX = (W0 > W1) ? W0 : W1;
    localparam int HMAX = (H0 > H1) ? H0 : H1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [CH-1:0]     din;
    logic              out_valid;
    logic              out_ready;
    logic [CH*KK-1:0]  win;
    logic              out_last;

    always #5 clk = ~clk;

    bin_window_gen #(.CH(CH), .K(K), .W0(W0), .H0(H0), .W1(W1), .H1(H1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .win(win), .out_last(out_last)
    );

    typedef struct {
        logic [CH*KK-1:0] w;
        logic             last;
    } exp_t;

    exp_t          sbq[$];
    logic [CH-1:0] img [0:HMAX-1][0:WMAX-1];
    int            m_row, m_col, m_mode;
    int            checks = 0;
    int            failures = 0;
    int            win_cnt, nz_cnt, last_cnt, stall_cnt;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_window win=%h required=none", win);
            end else begin
                e = sbq.pop_front();
                if (win !== e.w || out_last !== e.last) begin
                    failures++;
                    $display("FAIL window win=%h last=%b required win=%h last=%b",
                             win, out_last, e.w, e.last);
                end
                win_cnt++;
                if (win != '0) nz_cnt++;
                if (out_last) last_cnt++;
            end
        end
    end

    function automatic logic [CH-1:0] pix(input int pat, input int r, input int c);
        logic [CH-1:0] v;
        case (pat)
            0:       v = (r == 5 && c == 7) ? CH'(1) : CH'(0);
            1:       v = CH'(c % 2);
            default: v = CH'($urandom);
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_row = 0;
        m_col = 0;
        sbq.delete();
    endtask

    task automatic clear_counts();
        win_cnt = 0;
        nz_cnt = 0;
        last_cnt = 0;
        stall_cnt = 0;
    endtask

    task automatic model_accept(input logic [CH-1:0] d);
        int   w, h;
        exp_t e;
        if (m_row == 0 && m_col == 0) m_mode = mode;
        w = (m_mode != 0) ? W1 : W0;
        h = (m_mode != 0) ? H1 : H0;
        img[m_row][m_col] = d;
        if (m_row >= K - 1 && m_col >= K - 1) begin
            e.w = '0;
            for (int c = 0; c < CH; c++)
                for (int r = 0; r < K; r++)
                    for (int x = 0; x < K; x++)
                        e.w[c*KK + r*K + x] = img[m_row-K+1+r][m_col-K+1+x][c];
            e.last = (m_row == h - 1 && m_col == w - 1);
            sbq.push_back(e);
        end
        if (m_col == w - 1) begin
            m_col = 0;
            m_row = (m_row == h - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the pixel is taken.
    task automatic send_pixel(input int pat);
        logic [CH-1:0] d;
        int            waited;
        d = pix(pat, m_row, m_col);
        din = d;
        in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                model_accept(d);
                @(posedge clk); #1;
                in_valid = 1'b0;
                break;
            end
            waited++;
            stall_cnt++;
            if (waited > 50) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout waited=%0d required<=50", waited);
                @(posedge clk); #1;
                in_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int pat);
        int n;
        n = 0;
        do begin
            send_pixel(pat);
            n++;
        end while (!(m_row == 0 && m_col == 0) && n < 2000);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid === 1'b1) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; mode = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b1;
        m_mode = 0;
        model_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b required=0", out_last); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        checks++; if (win !== '0) begin failures++; $display("FAIL reset_win got=%h required=0", win); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b required=0", out_valid); end
        checks++; if (win !== '0) begin failures++; $display("FAIL idle_win got=%h required=0", win); end
        @(posedge clk); #1;
    endtask

    task automatic test_mode0_single_pixel();
        mode = 1'b0;
        clear_counts();
        send_frame(0);
        drain();
        checks++; if (win_cnt != 676) begin failures++; $display("FAIL m0_windows got=%0d required=676", win_cnt); end
        checks++; if (nz_cnt != 9) begin failures++; $display("FAIL m0_nonzero got=%0d required=9", nz_cnt); end
        checks++; if (last_cnt != 1) begin failures++; $display("FAIL m0_last got=%0d required=1", last_cnt); end
        checks++; if (stall_cnt != 0) begin failures++; $display("FAIL back_to_back stalls=%0d required=0", stall_cnt); end
    endtask

    task automatic test_mode1_stripes();
        mode = 1'b1;
        clear_counts();
        send_frame(1);
        drain();
        checks++; if (win_cnt != 100) begin failures++; $display("FAIL m1_windows got=%0d required=100", win_cnt); end
        checks++; if (nz_cnt != 100) begin failures++; $display("FAIL m1_nonzero got=%0d required=100", nz_cnt); end
        checks++; if (last_cnt != 1) begin failures++; $display("FAIL m1_last got=%0d required=1", last_cnt); end
    endtask

    task automatic test_backpressure();
        logic [CH*KK-1:0] snap;
        mode = 1'b0;
        clear_counts();
        repeat (400) send_pixel(2);
        out_ready = 1'b0;
        in_valid = 1'b1;
        din = '1;
        @(negedge clk);
        snap = win;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_start got=%b required=1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || win !== snap) begin
                failures++;
                $display("FAIL bp_stall cyc=%0d in_ready=%b out_valid=%b win=%h required 0/1/%h",
                         i, in_ready, out_valid, win, snap);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        send_frame(2);
        drain();
        checks++; if (win_cnt != 676) begin failures++; $display("FAIL bp_windows got=%0d required=676", win_cnt); end
    endtask

    task automatic test_mode_switch();
        mode = 1'b0;
        clear_counts();
        repeat (400) send_pixel(2);
        mode = 1'b1;
        send_frame(2);
        drain();
        checks++; if (win_cnt != 676) begin failures++; $display("FAIL switch_old_frame got=%0d required=676", win_cnt); end
        clear_counts();
        send_frame(2);
        drain();
        checks++; if (win_cnt != 100) begin failures++; $display("FAIL switch_new_frame got=%0d required=100", win_cnt); end
    endtask

    task automatic test_clear();
        mode = 1'b0;
        clear_counts();
        repeat (300) send_pixel(2);
        out_ready = 1'b0;
        clear = 1'b1;
        in_valid = 1'b1;
        din = '1;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL clear_outputs valid=%b last=%b required 0/0", out_valid, out_last); end
        @(posedge clk); #1;
        clear_counts();
        send_frame(2);
        drain();
        checks++; if (win_cnt != 676) begin failures++; $display("FAIL clear_windows got=%0d required=676", win_cnt); end
    endtask

    task automatic test_reset_pulse();
        mode = 1'b0;
        clear_counts();
        repeat (300) send_pixel(2);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0 || win !== '0) begin failures++; $display("FAIL arst_outputs valid=%b win=%h required 0/0", out_valid, win); end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        out_ready = 1'b1;
        clear_counts();
        send_frame(2);
        drain();
        checks++; if (win_cnt != 676) begin failures++; $display("FAIL arst_windows got=%0d required=676", win_cnt); end
    endtask

    initial begin
        test_reset();
        test_mode0_single_pixel();
        test_mode1_stripes();
        test_backpressure();
        test_mode_switch();
        test_clear();
        test_reset_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
